// File: rtl/multiport_regfile_sb_if.sv
// Decode-stage register file bus: read ports, writeback, link write, issue and scoreboard status.
// The master drives addresses, writes and issues. The slave returns read data and pending state.
interface multiport_regfile_sb_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int NUM_RD = 2
);
    logic [NUM_RD*ADDR_W-1:0] RdAddr;
    logic [NUM_RD*DATA_W-1:0] RdData;
    logic [NUM_RD-1:0]        RdPending;
    logic                     WbEnb;
    logic [ADDR_W-1:0]        WbAddr;
    logic [DATA_W-1:0]        WbData;
    logic                     WbOvf;
    logic                     LinkEnb;
    logic [DATA_W-1:0]        LinkPC;
    logic                     IssEnb;
    logic [ADDR_W-1:0]        IssAddr;
    logic [ADDR_W:0]          PendCnt;

    modport master (
        output RdAddr, WbEnb, WbAddr, WbData, WbOvf, LinkEnb, LinkPC, IssEnb, IssAddr,
        input  RdData, RdPending, PendCnt
    );

    modport slave (
        input  RdAddr, WbEnb, WbAddr, WbData, WbOvf, LinkEnb, LinkPC, IssEnb, IssAddr,
        output RdData, RdPending, PendCnt
    );
endinterface

// File: rtl/multiport_regfile_sb.sv
// Multi-read-port register file with writeback and link write ports and a pending-write scoreboard.
// Optional same-cycle write forwarding to the read ports is enabled with REGFILE_BYPASS_EN.
module multiport_regfile_sb #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int NUM_RD   = 2,
    parameter int LINK_REG = 31,
    parameter int LINK_OFS = 4
) (
    input logic                   Clk,
    input logic                   Rst,
    multiport_regfile_sb_if.slave bus
);
    localparam int NREG = 2**ADDR_W;

    logic [DATA_W-1:0]        regs [NREG];
    logic [NREG-1:0]          pend;
    logic [NREG-1:0]          pend_nxt;
    logic [ADDR_W:0]          pend_cnt;
    logic [ADDR_W:0]          cnt_nxt;
    logic [DATA_W-1:0]        link_data;
    logic                     wb_hit_link;
    logic                     wb_wr;
    logic [ADDR_W-1:0]        ra;
    logic [NUM_RD*DATA_W-1:0] rd_data;
    logic [NUM_RD-1:0]        rd_pend;

    assign link_data   = bus.LinkPC + DATA_W'(LINK_OFS);
    // On a collision at LINK_REG the link write wins and the writeback data is dropped.
    assign wb_hit_link = bus.LinkEnb && (bus.WbAddr == ADDR_W'(LINK_REG));
    assign wb_wr       = bus.WbEnb && !bus.WbOvf && (bus.WbAddr != '0) && !wb_hit_link;

    // A new producer issuing to a register supersedes the one retiring from it in the same cycle.
    always_comb begin
        // NOTE: every always_comb output is assigned a default first so no path can infer a latch.
        pend_nxt = '0;
        cnt_nxt  = '0;
        for (int r = 1; r < NREG; r++) begin
            pend_nxt[r] = (bus.IssEnb && bus.IssAddr == ADDR_W'(r))
                       || (pend[r]
                           && !(bus.WbEnb && bus.WbAddr == ADDR_W'(r))
                           && !(bus.LinkEnb && r == LINK_REG));
            cnt_nxt = cnt_nxt + (ADDR_W+1)'(pend_nxt[r]);
        end
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            // NOTE: the array is reset explicitly because r0 must read 0 and software expects a clean file.
            for (int r = 0; r < NREG; r++) begin
                regs[r] <= '0;
            end
            pend     <= '0;
            pend_cnt <= '0;
        end else begin
            // NOTE: state updates use non-blocking assignments so every process sees pre-edge values.
            if (wb_wr) begin
                regs[bus.WbAddr] <= bus.WbData;
            end
            if (bus.LinkEnb) begin
                regs[LINK_REG] <= link_data;
            end
            pend     <= pend_nxt;
            pend_cnt <= cnt_nxt;
        end
    end

    always_comb begin
        rd_data = '0;
        rd_pend = '0;
        ra      = '0;
        for (int i = 0; i < NUM_RD; i++) begin
            ra                          = bus.RdAddr[i*ADDR_W +: ADDR_W];
            rd_data[i*DATA_W +: DATA_W] = regs[ra];
            rd_pend[i]                  = pend[ra];
`ifdef REGFILE_BYPASS_EN
            // A retiring entry reports not-pending even when its data is suppressed by overflow.
            if (!Rst && ra != '0) begin
                if (bus.LinkEnb && ra == ADDR_W'(LINK_REG)) begin
                    rd_data[i*DATA_W +: DATA_W] = link_data;
                    rd_pend[i]                  = 1'b0;
                end else if (bus.WbEnb && ra == bus.WbAddr) begin
                    rd_pend[i] = 1'b0;
                    if (!bus.WbOvf) begin
                        rd_data[i*DATA_W +: DATA_W] = bus.WbData;
                    end
                end
            end
`endif
        end
    end

    assign bus.RdData    = rd_data;
    assign bus.RdPending = rd_pend;
    assign bus.PendCnt   = pend_cnt;
endmodule

// File: tb/tb_multiport_regfile_sb.sv
// Directed bench for multiport_regfile_sb with four read ports.
// Expectations follow whichever build is compiled: bypass (REGFILE_BYPASS_EN) or plain.
module tb_multiport_regfile_sb;
    logic Clk = 1'b0;
    logic Rst;
    int   n_cmp  = 0;
    int   n_fail = 0;

    always #5 Clk = ~Clk;

    multiport_regfile_sb_if #(.DATA_W(32), .ADDR_W(5), .NUM_RD(4)) bus ();

    multiport_regfile_sb #(
        .DATA_W(32), .ADDR_W(5), .NUM_RD(4), .LINK_REG(31), .LINK_OFS(4)
    ) dut (
        .Clk (Clk),
        .Rst (Rst),
        .bus (bus.slave)
    );

    function automatic logic [31:0] rdd(input int i);
        return bus.RdData[i*32 +: 32];
    endfunction

    task automatic set_rd(input int i, input logic [4:0] a);
        bus.RdAddr[i*5 +: 5] = a;
    endtask

    task automatic idle();
        bus.WbEnb   = 1'b0;
        bus.WbAddr  = '0;
        bus.WbData  = '0;
        bus.WbOvf   = 1'b0;
        bus.LinkEnb = 1'b0;
        bus.LinkPC  = '0;
        bus.IssEnb  = 1'b0;
        bus.IssAddr = '0;
    endtask

    // Advance one rising edge, settle, and drop the one-shot controls.
    task automatic tick();
        @(posedge Clk);
        #1;
        idle();
        #1;
    endtask

    task automatic wb(input logic [4:0] a, input logic [31:0] d);
        bus.WbEnb  = 1'b1;
        bus.WbAddr = a;
        bus.WbData = d;
    endtask

    task automatic iss(input logic [4:0] a);
        bus.IssEnb  = 1'b1;
        bus.IssAddr = a;
    endtask

    task automatic test_reset();
        Rst = 1'b1;
        idle();
        bus.RdAddr = '0;
        tick();
        Rst = 1'b0;
        wb(5'd3, 32'hAAAA_5555); tick();
        wb(5'd8, 32'h0000_0088); iss(5'd6); tick();
        set_rd(0, 5'd3); set_rd(1, 5'd8); set_rd(2, 5'd6); #1;
        n_cmp++;
        if (rdd(0) !== 32'hAAAA_5555) begin
            $display("FAIL pre_reset_r3: got %h want %h", rdd(0), 32'hAAAA_5555); n_fail++;
        end
        n_cmp++;
        if (bus.PendCnt !== 6'd1 || bus.RdPending[2] !== 1'b1) begin
            $display("FAIL pre_reset_pend: cnt %0d pend %b want 1 1", bus.PendCnt, bus.RdPending[2]); n_fail++;
        end
        Rst = 1'b1;
        tick();
        wb(5'd8, 32'd5); iss(5'd7); bus.LinkEnb = 1'b1; bus.LinkPC = 32'h40;
        tick();
        Rst = 1'b0;
        set_rd(3, 5'd31); #1;
        n_cmp++;
        if (bus.RdData !== '0) begin
            $display("FAIL reset_rddata: got %h want 0", bus.RdData); n_fail++;
        end
        n_cmp++;
        if (bus.RdPending !== 4'b0000 || bus.PendCnt !== 6'd0) begin
            $display("FAIL reset_pend: pend %b cnt %0d want 0000 0", bus.RdPending, bus.PendCnt); n_fail++;
        end
        set_rd(0, 5'd7); #1;
        n_cmp++;
        if (bus.RdPending[0] !== 1'b0) begin
            $display("FAIL reset_issue_ignored: got %b want 0", bus.RdPending[0]); n_fail++;
        end
    endtask

    task automatic test_issue_writeback();
        set_rd(0, 5'd9);
        iss(5'd9); tick();
        n_cmp++;
        if (bus.RdPending[0] !== 1'b1 || bus.PendCnt !== 6'd1) begin
            $display("FAIL iss_pend_c1: pend %b cnt %0d want 1 1", bus.RdPending[0], bus.PendCnt); n_fail++;
        end
        tick();
        n_cmp++;
        if (bus.RdPending[0] !== 1'b1) begin
            $display("FAIL iss_pend_c2: got %b want 1", bus.RdPending[0]); n_fail++;
        end
        wb(5'd9, 32'h1234); #1;
`ifdef REGFILE_BYPASS_EN
        n_cmp++;
        if (rdd(0) !== 32'h1234 || bus.RdPending[0] !== 1'b0) begin
            $display("FAIL wb_cycle_bypass: data %h pend %b want 1234 0", rdd(0), bus.RdPending[0]); n_fail++;
        end
`else
        n_cmp++;
        if (rdd(0) !== 32'h0 || bus.RdPending[0] !== 1'b1) begin
            $display("FAIL wb_cycle_nobypass: data %h pend %b want 0 1", rdd(0), bus.RdPending[0]); n_fail++;
        end
`endif
        tick();
        n_cmp++;
        if (rdd(0) !== 32'h1234 || bus.RdPending[0] !== 1'b0 || bus.PendCnt !== 6'd0) begin
            $display("FAIL wb_after: data %h pend %b cnt %0d want 1234 0 0", rdd(0), bus.RdPending[0], bus.PendCnt); n_fail++;
        end
    endtask

    task automatic test_overflow();
        wb(5'd10, 32'd30); tick();
        iss(5'd10); tick();
        set_rd(0, 5'd10); #1;
        n_cmp++;
        if (bus.PendCnt !== 6'd1 || rdd(0) !== 32'd30) begin
            $display("FAIL ovf_setup: cnt %0d data %0d want 1 30", bus.PendCnt, rdd(0)); n_fail++;
        end
        wb(5'd10, 32'd99); bus.WbOvf = 1'b1; #1;
`ifdef REGFILE_BYPASS_EN
        n_cmp++;
        if (rdd(0) !== 32'd30 || bus.RdPending[0] !== 1'b0) begin
            $display("FAIL ovf_cycle_bypass: data %0d pend %b want 30 0", rdd(0), bus.RdPending[0]); n_fail++;
        end
`else
        n_cmp++;
        if (rdd(0) !== 32'd30 || bus.RdPending[0] !== 1'b1) begin
            $display("FAIL ovf_cycle_nobypass: data %0d pend %b want 30 1", rdd(0), bus.RdPending[0]); n_fail++;
        end
`endif
        tick();
        n_cmp++;
        if (rdd(0) !== 32'd30 || bus.RdPending[0] !== 1'b0 || bus.PendCnt !== 6'd0) begin
            $display("FAIL ovf_after: data %0d pend %b cnt %0d want 30 0 0", rdd(0), bus.RdPending[0], bus.PendCnt); n_fail++;
        end
    endtask

    task automatic test_link_collision();
        set_rd(1, 5'd31);
        iss(5'd31); tick();
        bus.LinkEnb = 1'b1; bus.LinkPC = 32'h100; wb(5'd31, 32'd7); #1;
`ifdef REGFILE_BYPASS_EN
        n_cmp++;
        if (rdd(1) !== 32'h104 || bus.RdPending[1] !== 1'b0) begin
            $display("FAIL link_cycle_bypass: data %h pend %b want 104 0", rdd(1), bus.RdPending[1]); n_fail++;
        end
`else
        n_cmp++;
        if (rdd(1) !== 32'h0 || bus.RdPending[1] !== 1'b1) begin
            $display("FAIL link_cycle_nobypass: data %h pend %b want 0 1", rdd(1), bus.RdPending[1]); n_fail++;
        end
`endif
        tick();
        n_cmp++;
        if (rdd(1) !== 32'h104 || bus.RdPending[1] !== 1'b0 || bus.PendCnt !== 6'd0) begin
            $display("FAIL link_collision: data %h pend %b cnt %0d want 104 0 0", rdd(1), bus.RdPending[1], bus.PendCnt); n_fail++;
        end
        bus.LinkEnb = 1'b1; bus.LinkPC = 32'hFFFF_FFFE; tick();
        n_cmp++;
        if (rdd(1) !== 32'h2) begin
            $display("FAIL link_wrap: got %h want 2", rdd(1)); n_fail++;
        end
    endtask

    task automatic test_set_clear_same();
        set_rd(2, 5'd12);
        iss(5'd12); tick();
        iss(5'd12); wb(5'd12, 32'h55); tick();
        n_cmp++;
        if (bus.RdPending[2] !== 1'b1 || bus.PendCnt !== 6'd1 || rdd(2) !== 32'h55) begin
            $display("FAIL set_wins: pend %b cnt %0d data %h want 1 1 55", bus.RdPending[2], bus.PendCnt, rdd(2)); n_fail++;
        end
        wb(5'd12, 32'h66); tick();
        n_cmp++;
        if (bus.RdPending[2] !== 1'b0 || bus.PendCnt !== 6'd0 || rdd(2) !== 32'h66) begin
            $display("FAIL set_then_retire: pend %b cnt %0d data %h want 0 0 66", bus.RdPending[2], bus.PendCnt, rdd(2)); n_fail++;
        end
    endtask

    task automatic test_all_pending();
        for (int i = 0; i < 4; i++) set_rd(i, 5'd0);
        iss(5'd0); tick();
        n_cmp++;
        if (bus.PendCnt !== 6'd0) begin
            $display("FAIL iss_r0: cnt %0d want 0", bus.PendCnt); n_fail++;
        end
        for (int r = 1; r < 32; r++) begin
            iss(5'(r)); tick();
        end
        wb(5'd0, 32'hDEAD); tick();
        n_cmp++;
        if (bus.PendCnt !== 6'd31) begin
            $display("FAIL all_pend_cnt: got %0d want 31", bus.PendCnt); n_fail++;
        end
        n_cmp++;
        if (bus.RdData !== '0 || bus.RdPending !== 4'b0000) begin
            $display("FAIL r0_reads: data %h pend %b want 0 0000", bus.RdData, bus.RdPending); n_fail++;
        end
        set_rd(3, 5'd5); #1;
        n_cmp++;
        if (bus.RdPending !== 4'b1000) begin
            $display("FAIL r5_pending: got %b want 1000", bus.RdPending); n_fail++;
        end
        // Mid-operation reset drops every entry; a late writeback is then an ordinary write.
        Rst = 1'b1; tick(); Rst = 1'b0; #1;
        n_cmp++;
        if (bus.PendCnt !== 6'd0 || bus.RdPending !== 4'b0000) begin
            $display("FAIL midreset: cnt %0d pend %b want 0 0000", bus.PendCnt, bus.RdPending); n_fail++;
        end
        wb(5'd5, 32'h77); tick();
        n_cmp++;
        if (rdd(3) !== 32'h77 || bus.PendCnt !== 6'd0 || bus.RdPending[3] !== 1'b0) begin
            $display("FAIL late_wb: data %h cnt %0d pend %b want 77 0 0", rdd(3), bus.PendCnt, bus.RdPending[3]); n_fail++;
        end
    endtask

    task automatic test_back_to_back();
        set_rd(0, 5'd4); set_rd(1, 5'd5);
        iss(5'd4); tick();
        iss(5'd5); wb(5'd4, 32'hA4); tick();
        n_cmp++;
        if (bus.RdPending[1:0] !== 2'b10 || bus.PendCnt !== 6'd1 || rdd(0) !== 32'hA4) begin
            $display("FAIL b2b_1: pend %b cnt %0d data %h want 10 1 a4", bus.RdPending[1:0], bus.PendCnt, rdd(0)); n_fail++;
        end
        wb(5'd5, 32'hA5); tick();
        n_cmp++;
        if (bus.RdPending[1:0] !== 2'b00 || bus.PendCnt !== 6'd0 || rdd(1) !== 32'hA5) begin
            $display("FAIL b2b_2: pend %b cnt %0d data %h want 00 0 a5", bus.RdPending[1:0], bus.PendCnt, rdd(1)); n_fail++;
        end
    endtask

    initial begin
        test_reset();
        test_issue_writeback();
        test_overflow();
        test_link_collision();
        test_set_clear_same();
        test_all_pending();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
